sigma_delta_dac_multi: RTL and testbench

- Parametrised multi-channel sigma-delta audio DAC; converts NES/APU PCM samples into 1-bit pulse-density streams for RC-filtered audio pins.
- Generalises the single-channel first-order DAC: adds channel count, sample width, selectable first/second-order modulation and per-channel enable.
- Advances only on the NES clock enable (run_nes strobe), so density tracks the NES clock domain.

---
 rtl/sigma_delta_dac_multi.sv | 79 +++++++
 tb/tb_sigma_delta_dac_multi.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_dac_multi.sv
// Multi-channel sigma-delta DAC for NES/APU PCM samples; first- or second-order
// modulator per channel, advancing only on the cen strobe.
module sigma_delta_dac_multi #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8,
    parameter int ORDER    = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cen,
    input  logic [CHANNELS*WIDTH-1:0]    din,
    input  logic [CHANNELS-1:0]          chan_en,
    output logic [CHANNELS-1:0]          DACout
);

    localparam int IW = WIDTH + 4;
    // Two guard bits above the integrator width so sums cannot wrap before clamping.
    localparam int SW = WIDTH + 6;
    localparam logic signed [SW-1:0] HALF   = SW'(2 ** (WIDTH - 1));
    localparam logic signed [SW-1:0] SAT_HI = SW'((2 ** (WIDTH + 3)) - 1);
    localparam logic signed [SW-1:0] SAT_LO = -SAT_HI;

    function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] c;
        c = v;
        if (v > SAT_HI) c = SAT_HI;
        else if (v < SAT_LO) c = SAT_LO;
        return c[IW-1:0];
    endfunction

    for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
        logic [WIDTH-1:0] samp;

        always_ff @(posedge clock) begin
            if (reset || !chan_en[n]) samp <= '0;
            else if (cen)             samp <= din[n*WIDTH +: WIDTH];
        end

        if (ORDER == 1) begin : g_o1
            logic [WIDTH:0] acc;

            always_ff @(posedge clock) begin
                if (reset || !chan_en[n]) acc <= '0;
                else if (cen)             acc <= {1'b0, acc[WIDTH-1:0]} + {1'b0, samp};
            end

            assign DACout[n] = acc[WIDTH];
        end else begin : g_o2
            logic signed [IW-1:0] i1, i2;
            logic signed [IW-1:0] i1_next, i2_next;
            logic signed [SW-1:0] x, fb, s1, s2;
            logic                 dac;

            always_comb begin
                x       = $signed({{(SW-WIDTH){1'b0}}, samp}) - HALF;
                fb      = dac ? HALF : -HALF;
                s1      = {{(SW-IW){i1[IW-1]}}, i1} + x - fb;
                i1_next = sat(s1);
                s2      = {{(SW-IW){i2[IW-1]}}, i2} + {{(SW-IW){i1_next[IW-1]}}, i1_next} - fb;
                i2_next = sat(s2);
            end

            always_ff @(posedge clock) begin
                if (reset || !chan_en[n]) begin
                    i1  <= '0;
                    i2  <= '0;
                    dac <= 1'b0;
                end else if (cen) begin
                    i1  <= i1_next;
                    i2  <= i2_next;
                    dac <= ~i2_next[IW-1];
                end
            end

            assign DACout[n] = dac;
        end
    end

endmodule

// File: tb/tb_sigma_delta_dac_multi.sv
// Bench for sigma_delta_dac_multi: first- and second-order instances share stimulus
// and are checked against an integer reference model plus density counts.
module tb_sigma_delta_dac_multi;
    localparam int CH = 2;
    localparam int W  = 8;
    localparam int FS = 2 ** W;
    localparam int LIM = 2 ** (W + 3) - 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cen = 1'b0;
    logic [CH*W-1:0]   din = '0;
    logic [CH-1:0]     chan_en = '1;
    logic [CH-1:0]     dac1, dac2;

    int vectors = 0;
    int miscompares = 0;

    int samp_m[CH];
    int acc_m[CH];
    int i1_m[CH];
    int i2_m[CH];
    logic [CH-1:0] exp1 = '0;
    logic [CH-1:0] exp2 = '0;

    always #5 clock = ~clock;

    sigma_delta_dac_multi #(.CHANNELS(CH), .WIDTH(W), .ORDER(1)) u_o1 (
        .clock(clock), .reset(reset), .cen(cen), .din(din), .chan_en(chan_en), .DACout(dac1));
    sigma_delta_dac_multi #(.CHANNELS(CH), .WIDTH(W), .ORDER(2)) u_o2 (
        .clock(clock), .reset(reset), .cen(cen), .din(din), .chan_en(chan_en), .DACout(dac2));

    function automatic int sat(input int v);
        if (v > LIM) return LIM;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    // Reference: phase accumulator (order 1) and clamped double integrator (order 2).
    task automatic model_step(input logic r, input logic c, input logic [CH-1:0] en,
                              input logic [CH*W-1:0] d);
        int s, x, fb;
        for (int n = 0; n < CH; n++) begin
            if (r || !en[n]) begin
                samp_m[n] = 0; acc_m[n] = 0; i1_m[n] = 0; i2_m[n] = 0;
                exp1[n] = 1'b0; exp2[n] = 1'b0;
            end else if (c) begin
                s = samp_m[n];
                acc_m[n] = (acc_m[n] % FS) + s;
                exp1[n] = (acc_m[n] >= FS);
                x = s - FS / 2;
                fb = exp2[n] ? FS / 2 : -(FS / 2);
                i1_m[n] = sat(i1_m[n] + x - fb);
                i2_m[n] = sat(i2_m[n] + i1_m[n] - fb);
                exp2[n] = (i2_m[n] >= 0);
                samp_m[n] = int'((d >> (n * W)) & (FS - 1));
            end
        end
    endtask

    task automatic tick(input logic r, input logic c, input logic [CH-1:0] en,
                        input logic [CH*W-1:0] d);
        @(negedge clock);
        reset = r; cen = c; chan_en = en; din = d;
        @(posedge clock);
        model_step(r, c, en, d);
        #1;
    endtask

    task automatic test_reset;
        tick(1'b1, 1'b1, 2'b11, 16'hFFFF);
        vectors++;
        if (dac1 !== 2'b00 || dac2 !== 2'b00) begin
            miscompares++;
            $display("FAIL reset: dac1=%b dac2=%b required 00 00", dac1, dac2);
        end
    endtask

    task automatic test_o1_pattern;
        int j = 0;
        tick(1'b1, 1'b0, 2'b11, '0);
        for (int k = 0; k < 48; k++) begin
            tick(1'b0, (k % 4) == 3, 2'b11, 16'h0080);
            vectors++;
            if (dac1 !== exp1 || dac2 !== exp2) begin
                miscompares++;
                $display("FAIL o1_pattern_model clk %0d: dac1=%b exp %b dac2=%b exp %b", k, dac1, exp1, dac2, exp2);
            end
            if ((k % 4) == 3) begin
                vectors++;
                if (dac1[0] !== ((j >= 2) && (j % 2 == 0)) || dac1[1] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL o1_pattern cen %0d: dac1=%b required ch0=%0d ch1=0", j, dac1, (j >= 2) && (j % 2 == 0));
                end
                j++;
            end
        end
    endtask

    task automatic test_o1_density;
        int c0, c1;
        tick(1'b1, 1'b0, 2'b11, '0);
        tick(1'b0, 1'b1, 2'b11, 16'h40FF);
        for (int win = 0; win < 2; win++) begin
            c0 = 0; c1 = 0;
            for (int k = 0; k < FS; k++) begin
                tick(1'b0, 1'b1, 2'b11, 16'h40FF);
                c0 += int'(dac1[0]);
                c1 += int'(dac1[1]);
                vectors++;
                if (dac1 !== exp1 || dac2 !== exp2) begin
                    miscompares++;
                    $display("FAIL o1_density_model: dac1=%b exp %b dac2=%b exp %b", dac1, exp1, dac2, exp2);
                end
            end
            vectors++;
            if (c0 != 255 || c1 != 64) begin
                miscompares++;
                $display("FAIL o1_density win %0d: ones ch0=%0d ch1=%0d required 255 64", win, c0, c1);
            end
        end
    endtask

    task automatic test_o2_sweep;
        logic [7:0] vals[3] = '{8'h10, 8'h80, 8'hF0};
        logic [CH*W-1:0] d;
        int cnt, want;
        for (int v = 0; v < 3; v++) begin
            tick(1'b1, 1'b0, 2'b11, '0);
            d = {8'($urandom()), vals[v]};
            tick(1'b0, 1'b1, 2'b11, d);
            cnt = 0;
            for (int k = 0; k < 4 * FS; k++) begin
                d = {8'($urandom()), vals[v]};
                tick(1'b0, 1'b1, 2'b11, d);
                cnt += int'(dac2[0]);
                vectors++;
                if (dac1 !== exp1 || dac2 !== exp2) begin
                    miscompares++;
                    $display("FAIL o2_sweep_model: dac1=%b exp %b dac2=%b exp %b", dac1, exp1, dac2, exp2);
                end
            end
            want = 4 * int'(vals[v]);
            vectors++;
            if (cnt < want - 8 || cnt > want + 8) begin
                miscompares++;
                $display("FAIL o2_density din=%h: ones=%0d required %0d +-8", vals[v], cnt, want);
            end
        end
    endtask

    task automatic test_o2_square;
        logic [7:0] a, b;
        tick(1'b1, 1'b0, 2'b11, '0);
        for (int k = 0; k < 640; k++) begin
            a = ((k / 32) % 2) ? 8'hFF : 8'h00;
            b = (k % 2) ? 8'hFF : 8'h00;
            tick(1'b0, 1'b1, 2'b11, {b, a});
            vectors++;
            if (dac1 !== exp1 || dac2 !== exp2) begin
                miscompares++;
                $display("FAIL o2_square k %0d: dac1=%b exp %b dac2=%b exp %b", k, dac1, exp1, dac2, exp2);
            end
        end
    endtask

    task automatic test_cen_gating;
        logic [CH-1:0] h1, h2;
        tick(1'b1, 1'b0, 2'b11, '0);
        for (int k = 0; k < 60; k++) begin
            tick(1'b0, 1'($urandom()), 2'b11, 16'($urandom()));
            vectors++;
            if (dac1 !== exp1 || dac2 !== exp2) begin
                miscompares++;
                $display("FAIL gating_pre: dac1=%b exp %b dac2=%b exp %b", dac1, exp1, dac2, exp2);
            end
        end
        h1 = exp1; h2 = exp2;
        for (int k = 0; k < 100; k++) begin
            tick(1'b0, 1'b0, 2'b11, 16'($urandom()));
            vectors++;
            if (dac1 !== h1 || dac2 !== h2) begin
                miscompares++;
                $display("FAIL gating_hold clk %0d: dac1=%b held %b dac2=%b held %b", k, dac1, h1, dac2, h2);
            end
        end
        for (int k = 0; k < 200; k++) begin
            tick(1'b0, 1'($urandom()), 2'b11, 16'($urandom()));
            vectors++;
            if (dac1 !== exp1 || dac2 !== exp2) begin
                miscompares++;
                $display("FAIL gating_resume: dac1=%b exp %b dac2=%b exp %b", dac1, exp1, dac2, exp2);
            end
        end
    endtask

    task automatic test_chan_en;
        tick(1'b1, 1'b0, 2'b11, '0);
        for (int k = 0; k < 160; k++) begin
            logic [CH-1:0] en;
            en = (k >= 50 && k < 53) ? 2'b10 : 2'b11;
            tick(1'b0, (k % 3) != 0, en, 16'($urandom()));
            vectors++;
            if (dac1 !== exp1 || dac2 !== exp2) begin
                miscompares++;
                $display("FAIL chan_en_model clk %0d: dac1=%b exp %b dac2=%b exp %b", k, dac1, exp1, dac2, exp2);
            end
            if (!en[0]) begin
                vectors++;
                if (dac1[0] !== 1'b0 || dac2[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL chan_en_off: ch0 dac1=%b dac2=%b required 0", dac1[0], dac2[0]);
                end
            end
        end
    endtask

    task automatic test_reset_random;
        logic r;
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 19) == 0);
            tick(r, 1'($urandom()), 2'b11, 16'($urandom()));
            vectors++;
            if (dac1 !== exp1 || dac2 !== exp2) begin
                miscompares++;
                $display("FAIL reset_random_model clk %0d: dac1=%b exp %b dac2=%b exp %b", k, dac1, exp1, dac2, exp2);
            end
            if (r) begin
                vectors++;
                if (dac1 !== 2'b00 || dac2 !== 2'b00) begin
                    miscompares++;
                    $display("FAIL reset_random_zero: dac1=%b dac2=%b required 00 00", dac1, dac2);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_o1_pattern;
        test_o1_density;
        test_o2_sweep;
        test_o2_square;
        test_cen_gating;
        test_chan_en;
        test_reset_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end
endmodule
